// File: rtl/spi_responder_if.sv
// ---------------------------------------------------------------------------
// spi_responder_if
//   Groups the SPI link pins and the local register-write notification
//   signals of spi_responder.
//   master : the SPI initiator side (drives CS_n/MOSI, observes the rest)
//   slave  : the responder itself
//
//   CS_n         chip select, active low
//   MOSI         serial data from initiator
//   MISO         serial read data to initiator (driven 0 outside read window)
//   reg_wr_en    1-cycle pulse on committed write
//   reg_wr_addr  committed write address (held until next commit)
//   reg_wr_data  committed write data (held until next commit)
//   rd_done      1-cycle pulse after the last read bit was driven
//   frame_abort  1-cycle pulse when CS_n rises mid-frame
// ---------------------------------------------------------------------------
interface spi_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  CS_n;
  logic                  MOSI;
  logic                  MISO;
  logic                  reg_wr_en;
  logic [ADDR_WIDTH-1:0] reg_wr_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic                  rd_done;
  logic                  frame_abort;

  modport master (
    output CS_n, MOSI,
    input  MISO, reg_wr_en, reg_wr_addr, reg_wr_data, rd_done, frame_abort
  );

  modport slave (
    input  CS_n, MOSI,
    output MISO, reg_wr_en, reg_wr_addr, reg_wr_data, rd_done, frame_abort
  );
endinterface

// File: rtl/spi_responder.sv
// ---------------------------------------------------------------------------
// spi_responder
//   SPI target sharing SCLK with the initiator. Frames are
//   {LEAD_BITS discarded, Wr, addr MSB-first, data MSB-first (writes only)},
//   all sampled on posedge SCLK while CS_n is low. Writes commit into a
//   local register file; reads return the addressed register on MISO,
//   LSB-first, starting during the addr[0] sample.
//
//   SCLK    clock, all sampling on posedge
//   resetn  asynchronous active-low reset
//   bus     spi_responder_if.slave (CS_n, MOSI, MISO, reg_wr_*, rd_done,
//           frame_abort)
//
//   Assumes LEAD_BITS >= 1 and that a full frame fits in the 5-bit index.
// ---------------------------------------------------------------------------
module spi_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  parameter int LEAD_BITS  = 2
) (
  input  logic              SCLK,
  input  logic              resetn,
  spi_responder_if.slave    bus
);

  localparam int IDX_W  = 5;
  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Sample index of the last bit of each frame field.
  localparam logic [IDX_W-1:0] LEAD_LAST  = IDX_W'(LEAD_BITS - 1);
  localparam logic [IDX_W-1:0] ADDR_LAST  = IDX_W'(LEAD_BITS + ADDR_WIDTH);
  localparam logic [IDX_W-1:0] WDATA_LAST = IDX_W'(LEAD_BITS + ADDR_WIDTH + DATA_WIDTH);
  localparam logic [IDX_W-1:0] RDATA_LAST = IDX_W'(LEAD_BITS + ADDR_WIDTH + DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_A = (ADDR_WIDTH + 1)'(NUM_REGS);

  typedef enum logic [2:0] {IDLE, LEAD, CMD, ADDR, DATA_W, DATA_R, DONE} state_e;

  state_e                 state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic                   wr_flag;
  logic [ADDR_WIDTH-1:0]  addr_sh;
  logic [DATA_WIDTH-2:0]  d_sh;      // MSB is never needed: it shifts out at commit
  logic [DATA_WIDTH-1:0]  rd_sh;
  logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0]  full_addr; // address including the bit on MOSI now
  logic [DATA_WIDTH-1:0]  wdata;     // write data including the bit on MOSI now
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   rd_mapped, wr_mapped;
  logic                   frame_active, abort, commit, rd_load, rd_last, miso;

  assign full_addr = {addr_sh[ADDR_WIDTH-2:0], bus.MOSI};
  assign wdata     = {d_sh, bus.MOSI};
  assign rd_mapped = {1'b0, full_addr} < NUM_REGS_A;
  assign wr_mapped = {1'b0, addr_sh}   < NUM_REGS_A;
  assign rdata     = rd_mapped ? regs[full_addr[REG_AW-1:0]] : '0;

  // ---------------------------------------------------------------- state
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge SCLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // ----------------------------------------------------------- next state
  // NOTE: the default assignment up front keeps this purely combinational;
  // leaving any path unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    if (bus.CS_n) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = (LEAD_BITS > 1) ? LEAD : CMD;
        LEAD:    if (idx == LEAD_LAST)  state_nxt = CMD;
        CMD:     state_nxt = ADDR;
        ADDR:    if (idx == ADDR_LAST)  state_nxt = wr_flag ? DATA_W : DATA_R;
        DATA_W:  if (idx == WDATA_LAST) state_nxt = DONE;
        DATA_R:  if (idx == RDATA_LAST) state_nxt = DONE;
        DONE:    state_nxt = DONE;      // MOSI ignored until CS_n returns high
        default: state_nxt = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    frame_active = (state inside {LEAD, CMD, ADDR, DATA_W, DATA_R});
    abort        = bus.CS_n && frame_active;
    commit       = !bus.CS_n && (state == DATA_W) && (idx == WDATA_LAST);
    rd_load      = !bus.CS_n && (state == ADDR) && (idx == ADDR_LAST) && !wr_flag;
    rd_last      = !bus.CS_n && (state == DATA_R) && (idx == RDATA_LAST);
    miso         = 1'b0;
    // First read bit overlaps the addr[0] sample, so it bypasses rd_sh.
    if ((state == ADDR) && (idx == ADDR_LAST) && !wr_flag) miso = rdata[0];
    else if (state == DATA_R)                              miso = rd_sh[0];
  end

  assign bus.MISO = miso;

  // ------------------------------------------------------------- datapath
  always_ff @(posedge SCLK or negedge resetn) begin
    if (!resetn) begin
      idx     <= '0;
      wr_flag <= 1'b0;
      addr_sh <= '0;
      d_sh    <= '0;
      rd_sh   <= '0;
    end else begin
      idx <= bus.CS_n ? '0 : idx + 1'b1;
      if (!bus.CS_n) begin
        if (state == CMD)    wr_flag <= bus.MOSI;
        if (state == ADDR)   addr_sh <= full_addr;
        if (state == DATA_W) d_sh    <= wdata[DATA_WIDTH-2:0];
      end
      if (rd_load)                             rd_sh <= rdata >> 1;
      else if ((state == DATA_R) && !bus.CS_n) rd_sh <= rd_sh >> 1;
    end
  end

  // NOTE: the register file is cleared by reset because software relies on
  // reading zeros after resetn; a memory without reset would power up random.
  always_ff @(posedge SCLK or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_mapped) begin
      regs[addr_sh[REG_AW-1:0]] <= wdata;
    end
  end

  // Unmapped writes still report the commit so the initiator side can log it.
  always_ff @(posedge SCLK or negedge resetn) begin
    if (!resetn) begin
      bus.reg_wr_en   <= 1'b0;
      bus.reg_wr_addr <= '0;
      bus.reg_wr_data <= '0;
      bus.rd_done     <= 1'b0;
      bus.frame_abort <= 1'b0;
    end else begin
      bus.reg_wr_en   <= commit;
      bus.rd_done     <= rd_last;
      bus.frame_abort <= abort;
      if (commit) begin
        bus.reg_wr_addr <= addr_sh;
        bus.reg_wr_data <= wdata;
      end
    end
  end

endmodule
